// File: rtl/task_return_arbiter.sv
// Round-robin arbiter/sequencer for one shared output register written by multi-cycle tasks.
// A granted task either commits its latched data to o after EXEC_CYCLES or returns early on abort.
module task_return_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int EXEC_CYCLES = 3,
    localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_W      = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        abort,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      busy,
    output logic                      done,
    output logic [ID_W-1:0]           done_id,
    output logic                      returned_early,
    output logic [DATA_W-1:0]         o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   o_q, o_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [ID_W-1:0]     done_id_q, done_id_d;
    logic                early_q, early_d;

    logic                pick_found;
    logic [ID_W-1:0]     pick_id;

    // (base + k) mod NUM_REQ, valid for base < NUM_REQ and 0 <= k <= NUM_REQ
    function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_W'(s);
    endfunction

    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!pick_found && req[rr_idx(ptr_q, k)]) begin
                pick_found = 1'b1;
                pick_id    = rr_idx(ptr_q, k);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        id_d      = id_q;
        data_d    = data_q;
        o_d       = o_q;
        gnt_d     = gnt_q;
        busy_d    = busy_q;
        done_d    = done_q;
        done_id_d = done_id_q;
        early_d   = early_q;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    id_d    = pick_id;
                    data_d  = req_data[int'(pick_id)*DATA_W +: DATA_W];
                    gnt_d   = '0;
                    gnt_d[pick_id] = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = CNT_W'(EXEC_CYCLES - 1);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                gnt_d = '0;
                // abort has priority over the terminal count
                if (abort[id_q]) begin
                    done_d    = 1'b1;
                    early_d   = 1'b1;
                    done_id_d = id_q;
                    state_d   = DONE;
                end else if (cnt_q == '0) begin
                    o_d       = data_q;
                    done_d    = 1'b1;
                    early_d   = 1'b0;
                    done_id_d = id_q;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                ptr_d   = rr_idx(id_q, 1);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            id_q      <= '0;
            data_q    <= '0;
            o_q       <= '0;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            early_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            id_q      <= id_d;
            data_q    <= data_d;
            o_q       <= o_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            early_q   <= early_d;
        end
    end

    assign gnt            = gnt_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign done_id        = done_id_q;
    assign returned_early = early_q;
    assign o              = o_q;

endmodule
